// File: rtl/serial_subn.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a borrow flop.
// Computes a - b LSB first; publishes diff/borrow with a one-cycle done pulse.
module serial_subn #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [N-1:0]   res_sr;
    logic           br;
    logic [CW-1:0]  cnt;

    logic           a_i;
    logic           b_i;
    logic           d;
    logic           br_nxt;
    logic [N-1:0]   res_nxt;

    assign a_i     = a_sr[0];
    assign b_i     = b_sr[0];
    assign d       = a_i ^ b_i ^ br;
    assign br_nxt  = (~a_i & b_i) | (~(a_i ^ b_i) & br);
    assign res_nxt = {d, res_sr[N-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately ignored while an operation runs
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    br     <= br_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff   <= res_nxt;
                        borrow <= br_nxt;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subn.sv
// Directed scoreboard bench for serial_subn at N=8.
// Expected results are queued at start and checked when done pulses.
module tb_serial_subn;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [N-1:0] diff;
        logic         br;
        int           cyc;
    } exp_t;

    exp_t q[$];

    serial_subn #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("busy_done_excl", int'(busy & done), 0);
            if (done) begin
                chk("done_pending", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("done_cyc", cyc, e.cyc);
                    chk("diff", int'(diff), int'(e.diff));
                    chk("borrow", int'(borrow), int'(e.br));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [N-1:0] va, input logic [N-1:0] vb);
        exp_t e;
        e.diff = va - vb;
        e.br   = (va < vb);
        e.cyc  = cyc + N + 1;
        q.push_back(e);
        start = 1'b1;
        a     = va;
        b     = vb;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() != 0; i++) step();
        chk("done_timeout", q.size(), 0);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_borrow", int'(borrow), 0);
        step();
        rst_n = 1'b1;
        step();

        // basic, with busy window and done placement
        start_op(8'h05, 8'h03);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("basic_busy", int'(busy), 1);
            chk("basic_nodone", int'(done), 0);
            step();
        end
        @(negedge clk);
        chk("basic_done", int'(done), 1);
        chk("basic_busy_off", int'(busy), 0);
        step();
        @(negedge clk);
        chk("basic_done_once", int'(done), 0);
        step();

        start_op(8'h03, 8'h05); wait_done();
        start_op(8'h00, 8'h01); wait_done();
        start_op(8'hFF, 8'hFF); wait_done();
        start_op(8'h80, 8'h7F); wait_done();

        // start and operand change mid-run must be ignored
        start_op(8'h10, 8'h01);
        step();
        start = 1'b1;
        a     = 8'h00;
        b     = 8'hFF;
        step();
        start = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("prot_done", int'(done), 1);
        step();
        @(negedge clk);
        chk("prot_idle_busy", int'(busy), 0);
        chk("prot_idle_done", int'(done), 0);
        repeat (3) step();

        // back-to-back: restart in the DONE cycle
        start_op(8'h20, 8'h10);
        repeat (N) step();
        start_op(8'h01, 8'h02);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk("b2b_hold", int'(diff), 8'h10);
            chk("b2b_busy", int'(busy), 1);
            step();
        end
        wait_done();

        // async reset mid-run
        start_op(8'h05, 8'h03); wait_done();
        start_op(8'h44, 8'h11);
        repeat (3) step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_diff", int'(diff), 0);
        chk("arst_borrow", int'(borrow), 0);
        q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (12) step();
        @(negedge clk);
        chk("arst_idle", int'(busy), 0);
        step();
        start_op(8'h05, 8'h03); wait_done();

        for (int i = 0; i < 6; i++) begin
            start_op(N'($urandom), N'($urandom));
            wait_done();
        end

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
